sram_line_reader: RTL and testbench
===================================

Name: sram_line_reader

Overview:
- Read-side SRAM master for the frame buffer that the draw engine writes.
- On each line request, fetches one scanline of 16-bit words from external SRAM into a first-word-fall-through FIFO. The VGA/pixel side drains the FIFO.
- Shares the SRAM pins with the draw engine through an external arbiter (bus_req/bus_gnt).
- Never writes: WE is held high, so the external tristate buffer stays in read direction.

Parameters:
- LINE_WORDS, 320, words fetched per line request (1..1023).
- BASE_ADDR, 20'h00000, SRAM word address of line 0.
- READ_CYCLES, 2, cycles each SRAM read strobe is held (>=1).
- FIFO_DEPTH, 16, FIFO entries (power of 2, >=2).

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- line_start  in  1  one-cycle pulse requesting a line fetch.
- line_num  in  10  line index; sampled only when line_start is accepted.
- fifo_pop  in  1  consumer pop of FIFO head.
- fifo_data  out  16  FIFO head word; valid when fifo_empty=0.
- fifo_empty  out  1  FIFO holds no words.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words held.
- busy  out  1  high from line acceptance until the last word is pushed.
- err_overrun  out  1  sticky; set when line_start arrives while busy.
- err_underflow  out  1  sticky; set when fifo_pop arrives while empty.
- bus_req  out  1  SRAM bus request to the arbiter.
- bus_gnt  in  1  SRAM bus grant; may drop at any cycle.
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low.
- ADDR  out  20  SRAM word address.
- Data_from_SRAM  in  16  read data from the tristate buffer.

Behaviour:
- Reset:
  - FSM enters IDLE and the FIFO is emptied (fifo_count=0, fifo_empty=1, fifo_data=0).
  - busy=0, bus_req=0, err flags=0, ADDR=0.
  - CE=UB=LB=OE=WE=1.
  - Reset mid-fetch aborts immediately with the same values the next cycle.
- Outputs are registered. WE is constantly 1.
- FSM states: IDLE, REQ, READ, WAIT_SPACE.
- IDLE:
  - line_start=1 → latch line_num, flush FIFO, word_idx=0, busy=1, go to REQ.
- REQ:
  - bus_req=1, strobes high.
  - bus_gnt=1 → go to READ next cycle.
- READ:
  - CE=OE=UB=LB=0, bus_req=1.
  - ADDR = (BASE_ADDR + line*LINE_WORDS + word_idx) mod 2^20; wrap-around is silent.
  - ADDR and strobes are held stable for READ_CYCLES cycles.
  - On the last cycle, sample Data_from_SRAM and push it; fifo_count reflects the push one cycle later.
  - After the push:
    - If word_idx = LINE_WORDS-1: go to IDLE; busy, bus_req and strobes drop the next cycle.
    - Else if the FIFO is full after the push (pops in the same cycle considered): go to WAIT_SPACE.
    - Else: increment word_idx and start the next READ back-to-back. Throughput is one word per READ_CYCLES.
- WAIT_SPACE:
  - Strobes high, bus_req=0 to release the bus.
  - Leave when fifo_count < FIFO_DEPTH → REQ with the next word_idx.
- Grant loss: bus_gnt=0 during READ aborts the current word. Strobes go high the next cycle, nothing is pushed, and the FSM returns to REQ with the same word_idx.
- FIFO:
  - Head visible on fifo_data combinationally from storage.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pop on empty is ignored and sets err_underflow.
  - Never pushes when full.
- line_start while busy is ignored and sets err_overrun; the current fetch continues.
- line_start in the same cycle as the final push is treated as busy (ignored, flag set).
- Sticky flags clear only on Reset.

Test Plan:
1. Reset, BASE_ADDR=0, LINE_WORDS=4, READ_CYCLES=2, bus_gnt tied 1, line_start with line_num=3 → ADDR sequence 12,13,14,15, each held 2 cycles with OE=CE=0. FIFO ends at count 4 holding the SRAM model data in order. busy falls 1 cycle after the last push.
2. LINE_WORDS=40, FIFO_DEPTH=16, no pops → 16 words fetched, then WAIT_SPACE with bus_req=0 and strobes high. Popping 1 word → one more read at ADDR base+16.
3. bus_gnt drops in the 1st cycle of READ for word 5 → no push, strobes high next cycle. After the grant returns, ADDR=base+5 is re-read; the FIFO contains no duplicate and no gap.
4. line_start while busy → err_overrun=1 and the fetch completes unchanged. fifo_pop while empty → err_underflow=1 and fifo_count stays 0.
5. BASE_ADDR=20'hFFFFE, line_num=0, LINE_WORDS=4 → ADDR sequence FFFFE, FFFFF, 00000, 00001.
6. Reset asserted mid-READ → next cycle all strobes=1, bus_req=0, fifo_count=0, FSM in IDLE. A new line_start then works normally.

Source files
------------

// File: rtl/sram_line_reader.sv
// sram_line_reader
// Read-only SRAM master for the frame buffer. Each accepted line request
// fetches LINE_WORDS consecutive 16-bit words into a first-word-fall-through
// FIFO that the pixel side drains. The SRAM pins are shared with the draw
// engine through an external arbiter (bus_req / bus_gnt).
module sram_line_reader #(
    parameter int          LINE_WORDS  = 320,
    parameter logic [19:0] BASE_ADDR   = 20'h00000,
    parameter int          READ_CYCLES = 2,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        line_start,
    input  logic [9:0]                  line_num,
    input  logic                        fifo_pop,
    output logic [15:0]                 fifo_data,
    output logic                        fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        err_overrun,
    output logic                        err_underflow,
    output logic                        bus_req,
    input  logic                        bus_gnt,
    output logic                        CE,
    output logic                        UB,
    output logic                        LB,
    output logic                        OE,
    output logic                        WE,
    output logic [19:0]                 ADDR,
    input  logic [15:0]                 Data_from_SRAM
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CYC_W = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;

    localparam logic [9:0]       LAST_WORD  = 10'(LINE_WORDS - 1);
    localparam logic [CYC_W-1:0] LAST_CYC   = CYC_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ALMOST_CNT = CNT_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        READ,
        WAIT_SPACE
    } state_t;

    state_t             state, state_nxt;
    logic [9:0]         word_idx, word_idx_nxt;
    logic [CYC_W-1:0]   cyc_cnt, cyc_cnt_nxt;
    logic [19:0]        line_base, line_base_nxt;
    logic               flush;
    logic               push;

    logic               busy_nxt;
    logic               bus_req_nxt;
    logic               strobe_n, strobe_n_nxt;
    logic [19:0]        addr_nxt;

    logic [15:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               pop_ok;
    logic               push_ok;
    logic               full_after_push;

    // FIFO status seen by the FSM and the consumer.
    assign fifo_empty      = (fifo_count == '0);
    assign pop_ok          = fifo_pop && !fifo_empty;
    assign push_ok         = push && (fifo_count != FULL_CNT);
    assign full_after_push = (fifo_count == ALMOST_CNT) && !pop_ok;
    assign fifo_data       = fifo_empty ? 16'h0000 : mem[rd_ptr];

    // All four read strobes move together; the bus is never driven.
    assign CE = strobe_n;
    assign UB = strobe_n;
    assign LB = strobe_n;
    assign OE = strobe_n;
    assign WE = 1'b1;

    // Next-state logic; registered outputs are derived from the next state.
    // NOTE: every signal gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        word_idx_nxt  = word_idx;
        cyc_cnt_nxt   = cyc_cnt;
        line_base_nxt = line_base;
        flush         = 1'b0;
        push          = 1'b0;

        case (state)
            IDLE: begin
                if (line_start) begin
                    state_nxt     = REQ;
                    line_base_nxt = BASE_ADDR + 20'(line_num) * 20'(LINE_WORDS);
                    word_idx_nxt  = '0;
                    flush         = 1'b1;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_nxt   = READ;
                    cyc_cnt_nxt = '0;
                end
            end
            READ: begin
                if (!bus_gnt) begin
                    // Grant lost: drop this word and re-request it.
                    state_nxt = REQ;
                end else if (cyc_cnt == LAST_CYC) begin
                    push = 1'b1;
                    if (word_idx == LAST_WORD) begin
                        state_nxt = IDLE;
                    end else begin
                        word_idx_nxt = word_idx + 10'd1;
                        cyc_cnt_nxt  = '0;
                        state_nxt    = full_after_push ? WAIT_SPACE : READ;
                    end
                end else begin
                    cyc_cnt_nxt = cyc_cnt + CYC_W'(1);
                end
            end
            WAIT_SPACE: begin
                if (fifo_count < FULL_CNT) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt     = (state_nxt != IDLE);
        bus_req_nxt  = (state_nxt == REQ) || (state_nxt == READ);
        strobe_n_nxt = (state_nxt != READ);
        addr_nxt     = ADDR;
        if (state_nxt == READ) begin
            addr_nxt = line_base_nxt + {10'd0, word_idx_nxt};
        end
    end

    // FSM state and fetch bookkeeping.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            word_idx  <= '0;
            cyc_cnt   <= '0;
            line_base <= '0;
        end else begin
            state     <= state_nxt;
            word_idx  <= word_idx_nxt;
            cyc_cnt   <= cyc_cnt_nxt;
            line_base <= line_base_nxt;
        end
    end

    // Registered bus-side outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy     <= 1'b0;
            bus_req  <= 1'b0;
            strobe_n <= 1'b1;
            ADDR     <= '0;
        end else begin
            busy     <= busy_nxt;
            bus_req  <= bus_req_nxt;
            strobe_n <= strobe_n_nxt;
            ADDR     <= addr_nxt;
        end
    end

    // FIFO pointers and occupancy; a new line flushes any leftover words.
    always_ff @(posedge Clk) begin
        if (Reset || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage written with the word sampled on the last read cycle.
    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers and fifo_data is forced to zero while empty.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= Data_from_SRAM;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            err_overrun   <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (line_start && (state != IDLE)) begin
                err_overrun <= 1'b1;
            end
            if (fifo_pop && fifo_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_line_reader.sv
// Self-checking bench for sram_line_reader. Three instances cover the
// short-line, FIFO-backpressure/grant-loss and address-wrap configurations.
// Expected words are queued when a line is requested and compared on pop.
module tb_sram_line_reader;

    logic        clk;
    logic        rst;
    logic        line_start [3];
    logic [9:0]  line_num   [3];
    logic        pop        [3];
    logic [15:0] fdata      [3];
    logic        fempty     [3];
    logic [4:0]  fcount     [3];
    logic        busy       [3];
    logic        err_ov     [3];
    logic        err_un     [3];
    logic        req        [3];
    logic        gnt        [3];
    logic        ce         [3];
    logic        ub         [3];
    logic        lb         [3];
    logic        oe         [3];
    logic        we         [3];
    logic [19:0] addr       [3];
    logic [15:0] din        [3];

    int          vectors;
    int          miscompares;
    logic [15:0] sb [$];
    logic [19:0] trace [$];
    int          busy_fall;
    int          last_low;
    int          bad_strobe;

    // SRAM content model: data is only driven while the chip is read-enabled.
    function automatic logic [15:0] sram_word(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], a[19:16], a[19:16], a[19:16]} ^ 16'h3C5A;
    endfunction

    function automatic logic [19:0] exp_addr(input logic [19:0] base, input int ln,
                                             input int lw, input int i);
        logic [31:0] s;
        s = 32'(base) + 32'(ln * lw) + 32'(i);
        return s[19:0];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_sram
        assign din[g] = (!ce[g] && !oe[g]) ? sram_word(addr[g]) : 16'hDEAD;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sram_line_reader #(.LINE_WORDS(4), .BASE_ADDR(20'h00000), .READ_CYCLES(2), .FIFO_DEPTH(16)) u_a (
        .Clk(clk), .Reset(rst), .line_start(line_start[0]), .line_num(line_num[0]),
        .fifo_pop(pop[0]), .fifo_data(fdata[0]), .fifo_empty(fempty[0]), .fifo_count(fcount[0]),
        .busy(busy[0]), .err_overrun(err_ov[0]), .err_underflow(err_un[0]), .bus_req(req[0]),
        .bus_gnt(gnt[0]), .CE(ce[0]), .UB(ub[0]), .LB(lb[0]), .OE(oe[0]), .WE(we[0]),
        .ADDR(addr[0]), .Data_from_SRAM(din[0])
    );

    sram_line_reader #(.LINE_WORDS(40), .BASE_ADDR(20'h00100), .READ_CYCLES(2), .FIFO_DEPTH(16)) u_b (
        .Clk(clk), .Reset(rst), .line_start(line_start[1]), .line_num(line_num[1]),
        .fifo_pop(pop[1]), .fifo_data(fdata[1]), .fifo_empty(fempty[1]), .fifo_count(fcount[1]),
        .busy(busy[1]), .err_overrun(err_ov[1]), .err_underflow(err_un[1]), .bus_req(req[1]),
        .bus_gnt(gnt[1]), .CE(ce[1]), .UB(ub[1]), .LB(lb[1]), .OE(oe[1]), .WE(we[1]),
        .ADDR(addr[1]), .Data_from_SRAM(din[1])
    );

    sram_line_reader #(.LINE_WORDS(4), .BASE_ADDR(20'hFFFFE), .READ_CYCLES(2), .FIFO_DEPTH(16)) u_c (
        .Clk(clk), .Reset(rst), .line_start(line_start[2]), .line_num(line_num[2]),
        .fifo_pop(pop[2]), .fifo_data(fdata[2]), .fifo_empty(fempty[2]), .fifo_count(fcount[2]),
        .busy(busy[2]), .err_overrun(err_ov[2]), .err_underflow(err_un[2]), .bus_req(req[2]),
        .bus_gnt(gnt[2]), .CE(ce[2]), .UB(ub[2]), .LB(lb[2]), .OE(oe[2]), .WE(we[2]),
        .ADDR(addr[2]), .Data_from_SRAM(din[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a line, queue its expected words and record the address trace
    // of every strobed cycle until busy falls. ovr_cyc >= 0 fires a second
    // line_start at that trace cycle.
    task automatic run_fetch(input int u, input int ln, input logic [19:0] base,
                             input int lw, input int ovr_cyc);
        for (int i = 0; i < lw; i++) sb.push_back(sram_word(exp_addr(base, ln, lw, i)));
        line_num[u]   = 10'(ln);
        line_start[u] = 1'b1;
        tick();
        line_start[u] = 1'b0;
        trace.delete();
        busy_fall  = -1;
        last_low   = -1;
        bad_strobe = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (!busy[u]) begin
                busy_fall = cyc;
                break;
            end
            if (cyc == ovr_cyc) begin
                line_num[u]   = 10'd9;
                line_start[u] = 1'b1;
            end else begin
                line_start[u] = 1'b0;
            end
            if ({ub[u], lb[u], oe[u]} !== {3{ce[u]}} || we[u] !== 1'b1) bad_strobe++;
            if (!ce[u]) begin
                trace.push_back(addr[u]);
                last_low = cyc;
            end
            tick();
        end
        line_start[u] = 1'b0;
    endtask

    // Pop everything the instance produces, comparing against the scoreboard.
    task automatic drain(input int u, input string tag);
        logic [15:0] exp;
        int popped;
        popped = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (fempty[u] && !busy[u]) break;
            if (!fempty[u]) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s_extra_word: got %h, no word expected", tag, fdata[u]);
                end else begin
                    exp = sb.pop_front();
                    if (fdata[u] !== exp) begin
                        miscompares++;
                        $display("FAIL %s_word%0d: got %h want %h", tag, popped, fdata[u], exp);
                    end
                end
                popped++;
                pop[u] = 1'b1;
            end else begin
                pop[u] = 1'b0;
            end
            tick();
        end
        pop[u] = 1'b0;
        vectors++;
        if (!(fempty[u] && !busy[u]) || sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_complete: empty=%b busy=%b words_left=%0d want 1 0 0",
                     tag, fempty[u], busy[u], sb.size());
        end
    endtask

    task automatic check_trace(input string tag, input logic [19:0] base, input int ln, input int lw);
        logic [19:0] exp;
        vectors++;
        if (trace.size() != 2 * lw) begin
            miscompares++;
            $display("FAIL %s_trace_len: got %0d want %0d", tag, trace.size(), 2 * lw);
        end else begin
            for (int k = 0; k < 2 * lw; k++) begin
                exp = exp_addr(base, ln, lw, k / 2);
                vectors++;
                if (trace[k] !== exp) begin
                    miscompares++;
                    $display("FAIL %s_addr%0d: got %h want %h", tag, k, trace[k], exp);
                end
            end
        end
        vectors++;
        if (bad_strobe != 0) begin
            miscompares++;
            $display("FAIL %s_strobes: %0d cycles with split strobes or WE low, want 0", tag, bad_strobe);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int u = 0; u < 3; u++) begin
            vectors++;
            if ({busy[u], req[u], ce[u], ub[u], lb[u], oe[u], we[u], err_ov[u], err_un[u], fempty[u],
                 fcount[u], fdata[u], addr[u]} !== {10'b0011111001, 5'd0, 16'd0, 20'd0}) begin
                miscompares++;
                $display("FAIL reset_state_u%0d: busy=%b req=%b ce=%b oe=%b we=%b err=%b%b empty=%b cnt=%0d data=%h addr=%h",
                         u, busy[u], req[u], ce[u], oe[u], we[u], err_ov[u], err_un[u], fempty[u],
                         fcount[u], fdata[u], addr[u]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_line_fetch();
        run_fetch(0, 3, 20'h00000, 4, -1);
        check_trace("fetch", 20'h00000, 3, 4);
        vectors++;
        if (busy_fall != last_low + 1 || last_low < 0) begin
            miscompares++;
            $display("FAIL fetch_busy_fall: fell at %0d want %0d", busy_fall, last_low + 1);
        end
        vectors++;
        if (fcount[0] !== 5'd4) begin
            miscompares++;
            $display("FAIL fetch_count: got %0d want 4", fcount[0]);
        end
        drain(0, "fetch");
    endtask

    task automatic test_overrun_underflow();
        run_fetch(0, 1, 20'h00000, 4, 0);
        vectors++;
        if (err_ov[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_flag: got %b want 1", err_ov[0]);
        end
        check_trace("overrun", 20'h00000, 1, 4);
        drain(0, "overrun");
        pop[0] = 1'b1;
        tick();
        pop[0] = 1'b0;
        vectors++;
        if ({err_un[0], fcount[0], fempty[0]} !== {1'b1, 5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL underflow: err=%b count=%0d empty=%b want 1 0 1", err_un[0], fcount[0], fempty[0]);
        end
    endtask

    task automatic test_wait_space();
        logic [15:0] exp;
        logic        reached;
        for (int i = 0; i < 40; i++) sb.push_back(sram_word(exp_addr(20'h00100, 2, 40, i)));
        line_num[1]   = 10'd2;
        line_start[1] = 1'b1;
        tick();
        line_start[1] = 1'b0;
        trace.delete();
        reached = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (busy[1] && !req[1]) begin
                reached = 1'b1;
                break;
            end
            if (!ce[1]) trace.push_back(addr[1]);
            tick();
        end
        vectors++;
        if (!reached || fcount[1] !== 5'd16 || {ce[1], ub[1], lb[1], oe[1]} !== 4'hF) begin
            miscompares++;
            $display("FAIL wait_space_entry: reached=%b count=%0d strobes=%b%b%b%b want 1 16 1111",
                     reached, fcount[1], ce[1], ub[1], lb[1], oe[1]);
        end
        vectors++;
        if (trace.size() != 32 || trace[31] !== 20'h0015F) begin
            miscompares++;
            $display("FAIL wait_space_reads: samples=%0d last=%h want 32 0015f",
                     trace.size(), (trace.size() > 0) ? trace[trace.size() - 1] : 20'h0);
        end
        tick();
        tick();
        vectors++;
        if ({req[1], ce[1], busy[1]} !== 3'b011 || fcount[1] !== 5'd16) begin
            miscompares++;
            $display("FAIL wait_space_hold: req=%b ce=%b busy=%b count=%0d want 0 1 1 16",
                     req[1], ce[1], busy[1], fcount[1]);
        end
        exp = sb.pop_front();
        vectors++;
        if (fdata[1] !== exp) begin
            miscompares++;
            $display("FAIL wait_space_head: got %h want %h", fdata[1], exp);
        end
        pop[1] = 1'b1;
        tick();
        pop[1] = 1'b0;
        for (int cyc = 0; cyc < 20 && ce[1]; cyc++) tick();
        vectors++;
        if (ce[1] !== 1'b0 || addr[1] !== 20'h00160) begin
            miscompares++;
            $display("FAIL wait_space_resume: ce=%b addr=%h want 0 00160", ce[1], addr[1]);
        end
        drain(1, "wait_space");
    endtask

    task automatic test_grant_loss();
        logic found;
        for (int i = 0; i < 40; i++) sb.push_back(sram_word(exp_addr(20'h00100, 0, 40, i)));
        line_num[1]   = 10'd0;
        line_start[1] = 1'b1;
        tick();
        line_start[1] = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (!ce[1] && addr[1] == 20'h00105) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        gnt[1] = 1'b0;
        tick();
        vectors++;
        if (!found || {ce[1], oe[1], ub[1], lb[1]} !== 4'hF || fcount[1] !== 5'd5) begin
            miscompares++;
            $display("FAIL grant_abort: found=%b strobes=%b%b%b%b count=%0d want 1 1111 5",
                     found, ce[1], oe[1], ub[1], lb[1], fcount[1]);
        end
        tick();
        tick();
        vectors++;
        if ({req[1], ce[1], busy[1]} !== 3'b111 || fcount[1] !== 5'd5) begin
            miscompares++;
            $display("FAIL grant_wait: req=%b ce=%b busy=%b count=%0d want 1 1 1 5",
                     req[1], ce[1], busy[1], fcount[1]);
        end
        gnt[1] = 1'b1;
        for (int cyc = 0; cyc < 20 && ce[1]; cyc++) tick();
        vectors++;
        if (ce[1] !== 1'b0 || addr[1] !== 20'h00105) begin
            miscompares++;
            $display("FAIL grant_reread: ce=%b addr=%h want 0 00105", ce[1], addr[1]);
        end
        drain(1, "grant");
    endtask

    task automatic test_addr_wrap();
        run_fetch(2, 0, 20'hFFFFE, 4, -1);
        check_trace("wrap", 20'hFFFFE, 0, 4);
        drain(2, "wrap");
    endtask

    task automatic test_reset_mid_read();
        logic hit;
        line_num[0]   = 10'd2;
        line_start[0] = 1'b1;
        tick();
        line_start[0] = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (!ce[0] && fcount[0] != 5'd0) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (!hit || {busy[0], req[0], ce[0], ub[0], lb[0], oe[0], we[0], err_ov[0], err_un[0], fempty[0],
                     fcount[0], fdata[0], addr[0]} !== {10'b0011111001, 5'd0, 16'd0, 20'd0}) begin
            miscompares++;
            $display("FAIL reset_mid_read: hit=%b busy=%b req=%b ce=%b err=%b%b cnt=%0d data=%h addr=%h",
                     hit, busy[0], req[0], ce[0], err_ov[0], err_un[0], fcount[0], fdata[0], addr[0]);
        end
        tick();
        vectors++;
        if (busy[0] !== 1'b0 || req[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b req=%b want 0 0", busy[0], req[0]);
        end
        // line_start landing on the final-push cycle must be ignored.
        run_fetch(0, 5, 20'h00000, 4, 8);
        check_trace("restart", 20'h00000, 5, 4);
        vectors++;
        if (err_ov[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL final_push_overrun: got %b want 1", err_ov[0]);
        end
        tick();
        vectors++;
        if (busy[0] !== 1'b0 || fcount[0] !== 5'd4) begin
            miscompares++;
            $display("FAIL final_push_ignored: busy=%b count=%0d want 0 4", busy[0], fcount[0]);
        end
        drain(0, "restart");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        for (int u = 0; u < 3; u++) begin
            line_start[u] = 1'b0;
            line_num[u]   = 10'd0;
            pop[u]        = 1'b0;
            gnt[u]        = 1'b1;
        end
        test_reset();
        test_line_fetch();
        test_overrun_underflow();
        test_wait_space();
        test_grant_loss();
        test_addr_wrap();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
